// File: rtl/camera_frame_writer.sv
// Captures DVP camera bytes into a 16-deep pixel FIFO and offers each pixel with its
// row/column address to an SDRAM writer. Define CAM_TEST_PATTERN_EN for colour-bar pixels.
module camera_frame_writer #(
    parameter int H_PIXELS = 800,
    parameter int V_LINES  = 600,
    parameter int FIFO_AW  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cam_pclk,
    input  logic        cam_href,
    input  logic        cam_vsync,
    input  logic [7:0]  cam_data,
    output logic [15:0] DATA_out,
    output logic [23:0] DATA_addr,
    output logic        WriteFlag,
    input  logic        DATA_out_ack,
    output logic        frame_done,
    output logic        overflow
);
    localparam int CW    = 11;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [CW:0]      H_LIM    = (CW+1)'(H_PIXELS);
    localparam logic [CW:0]      V_LIM    = (CW+1)'(V_LINES);
    localparam logic [CW-1:0]    COL_LAST = CW'(H_PIXELS - 1);
    localparam logic [CW-1:0]    ROW_LAST = CW'(V_LINES - 1);
    localparam logic [CW-1:0]    CNT_MAX  = '1;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

    typedef enum logic {S_WAITFRAME, S_CAPTURE} state_t;

    typedef struct packed {
        logic [15:0]   pix;
        logic [CW-1:0] col;
        logic [CW-1:0] row;
    } entry_t;

    logic [1:0] pclk_sync, href_sync, vsync_sync;
    logic [7:0] data_q1, data_q2;
    logic       pclk_d, href_d, vsync_d;

    // NOTE: sequential state uses non-blocking assignments only, with an asynchronous
    // active-low reset, so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pclk_sync  <= '0;
            href_sync  <= '0;
            vsync_sync <= '0;
            data_q1    <= '0;
            data_q2    <= '0;
            pclk_d     <= 1'b0;
            href_d     <= 1'b0;
            vsync_d    <= 1'b0;
        end else begin
            pclk_sync  <= {pclk_sync[0], cam_pclk};
            href_sync  <= {href_sync[0], cam_href};
            vsync_sync <= {vsync_sync[0], cam_vsync};
            // Data takes the same two-cycle path so it lines up with the synced strobe.
            data_q1    <= cam_data;
            data_q2    <= data_q1;
            pclk_d     <= pclk_sync[1];
            href_d     <= href_sync[1];
            vsync_d    <= vsync_sync[1];
        end
    end

    logic pclk_rise, href_fall, vsync_rise, vsync_fall;
    assign pclk_rise  = pclk_sync[1] & ~pclk_d;
    assign href_fall  = ~href_sync[1] & href_d;
    assign vsync_rise = vsync_sync[1] & ~vsync_d;
    assign vsync_fall = ~vsync_sync[1] & vsync_d;

    state_t state, state_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_WAITFRAME;
        else      state <= state_next;
    end

    // NOTE: every always_comb output gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_WAITFRAME: if (vsync_fall) state_next = S_CAPTURE;
            S_CAPTURE:   if (vsync_rise) state_next = S_WAITFRAME;
        endcase
    end

    logic          phase;
    logic [7:0]    hi_byte;
    logic [CW-1:0] col_cnt, row_cnt;
    logic          byte_strobe;

    assign byte_strobe = (state == S_CAPTURE) && pclk_rise && href_sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase   <= 1'b0;
            hi_byte <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (state == S_WAITFRAME) begin
            phase   <= 1'b0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (href_fall) begin
            phase   <= 1'b0;
            col_cnt <= '0;
            if (col_cnt != '0 && row_cnt != CNT_MAX) row_cnt <= row_cnt + 1'b1;
        end else if (byte_strobe) begin
            phase <= ~phase;
            if (!phase) hi_byte <= data_q2;
            // Columns keep counting past the stored width so overlong lines stay discarded.
            else if (col_cnt != CNT_MAX) col_cnt <= col_cnt + 1'b1;
        end
    end

    logic [15:0] pixel;
`ifdef CAM_TEST_PATTERN_EN
    assign pixel = {4'h0, {4{col_cnt[7]}}, {4{col_cnt[8]}}, {4{col_cnt[9]}}};
`else
    assign pixel = {hi_byte, data_q2};
`endif

    logic               push_req, in_range, full, push, pop, drop;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count, count_next;
    entry_t             mem [DEPTH];
    entry_t             head;

    assign push_req = byte_strobe && phase;
    assign in_range = ({1'b0, col_cnt} < H_LIM) && ({1'b0, row_cnt} < V_LIM);
    assign full     = (count == FULL_CNT);
    assign pop      = DATA_out_ack && WriteFlag;
    assign push     = push_req && in_range && (!full || pop);
    assign drop     = push_req && in_range && full && !pop;
    assign head     = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 1'b1;
        else if (pop && !push) count_next = count - 1'b1;
    end

    // NOTE: the storage array is deliberately not reset; count and the pointers alone
    // decide which entries are valid, and the outputs are gated while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {pixel, col_cnt, row_cnt};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            WriteFlag  <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count      <= count_next;
            WriteFlag  <= (count_next != '0);
            frame_done <= pop && (head.col == COL_LAST) && (head.row == ROW_LAST);
            if (state == S_WAITFRAME && vsync_fall) overflow <= 1'b0;
            else if (drop)                          overflow <= 1'b1;
        end
    end

    assign DATA_out  = WriteFlag ? head.pix : '0;
    assign DATA_addr = WriteFlag ? {2'b00, head.row, head.col} : '0;

endmodule

// File: tb/tb_camera_frame_writer.sv
// Directed bench for camera_frame_writer: a queue model of expected pixel writes is
// checked against every acknowledged DUT word, plus hand-computed end-of-test literals.
module tb_camera_frame_writer;
    localparam int H = 800;
    localparam int V = 4;

`ifdef CAM_TEST_PATTERN_EN
    localparam logic [15:0] T1_LAST = 16'h00FF;
    localparam logic [15:0] T2_LAST = 16'h00FF;
`else
    localparam logic [15:0] T1_LAST = 16'h1234;
    localparam logic [15:0] T2_LAST = 16'h3E3F;
`endif
    localparam logic [15:0] T3_LAST_RAW = 16'hA00F;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cam_pclk = 1'b0;
    logic        cam_href = 1'b0;
    logic        cam_vsync = 1'b1;
    logic [7:0]  cam_data = 8'h00;
    logic [15:0] DATA_out;
    logic [23:0] DATA_addr;
    logic        WriteFlag;
    logic        DATA_out_ack = 1'b0;
    logic        frame_done;
    logic        overflow;

    always #5 clk = ~clk;

    camera_frame_writer #(.H_PIXELS(H), .V_LINES(V), .FIFO_AW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cam_pclk     (cam_pclk),
        .cam_href     (cam_href),
        .cam_vsync    (cam_vsync),
        .cam_data     (cam_data),
        .DATA_out     (DATA_out),
        .DATA_addr    (DATA_addr),
        .WriteFlag    (WriteFlag),
        .DATA_out_ack (DATA_out_ack),
        .frame_done   (frame_done),
        .overflow     (overflow)
    );

    typedef struct {
        logic [15:0] pix;
        int          col;
        int          row;
    } exp_t;

    exp_t        model_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    bit          ack_en = 0;
    bit          poke_ack = 0;
    bit          live = 0;
    bit          final_pop = 0;
    int          cur_col = 0;
    int          cur_row = 0;
    int          pops = 0;
    int          fd_count = 0;
    logic [23:0] last_addr = '0;
    logic [15:0] last_pix = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] expected_pix(input logic [7:0] hi, input logic [7:0] lo,
                                                 input int col);
`ifdef CAM_TEST_PATTERN_EN
        logic [15:0] p;
        p = 16'h0000;
        if (((col / 128) % 2) == 1) p = p | 16'h0F00;
        if (((col / 256) % 2) == 1) p = p | 16'h00F0;
        if (((col / 512) % 2) == 1) p = p | 16'h000F;
        return p;
`else
        return {hi, lo};
`endif
    endfunction

    // Compare process: acks every word the DUT offers and checks it against the model.
    always @(negedge clk) begin
        bit   fd_exp;
        exp_t e;
        fd_exp    = final_pop;
        final_pop = 0;
        if (frame_done) fd_count++;
        if (frame_done || fd_exp) check("frame_done", frame_done, fd_exp);
        DATA_out_ack = poke_ack;
        if (WriteFlag && model_q.size() == 0) begin
            check("unexpected_writeflag", WriteFlag, 0);
        end else if (WriteFlag && ack_en) begin
            e = model_q.pop_front();
            check("data_out", DATA_out, e.pix);
            check("data_addr", DATA_addr, (e.row << 11) | e.col);
            final_pop    = (e.col == H - 1) && (e.row == V - 1);
            last_addr    = DATA_addr;
            last_pix     = DATA_out;
            pops++;
            DATA_out_ack = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_data = b;
        cam_pclk = 1'b0;
        tick(2);
        cam_pclk = 1'b1;
        tick(2);
    endtask

    task automatic send_px(input logic [7:0] hi, input logic [7:0] lo);
        exp_t e;
        send_byte(hi);
        send_byte(lo);
        if (live && cur_col < H && cur_row < V && (ack_en || model_q.size() < 16)) begin
            e.pix = expected_pix(hi, lo, cur_col);
            e.col = cur_col;
            e.row = cur_row;
            model_q.push_back(e);
        end
        cur_col++;
    endtask

    task automatic line_begin();
        cam_href = 1'b1;
    endtask

    task automatic line_end();
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        tick(8);
        if (live && cur_col > 0) cur_row++;
        cur_col = 0;
    endtask

    task automatic new_frame();
        cam_vsync = 1'b1;
        tick(6);
        cam_vsync = 1'b0;
        tick(6);
        live    = 1;
        cur_row = 0;
        cur_col = 0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((model_q.size() != 0 || WriteFlag) && t < 400) begin
            tick(1);
            t++;
        end
        check({name, "_model_drained"}, model_q.size(), 0);
        check({name, "_writeflag_low"}, WriteFlag, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int fd0;

        tick(3);
        check("reset_writeflag", WriteFlag, 0);
        check("reset_data_out", DATA_out, 0);
        check("reset_data_addr", DATA_addr, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_overflow", overflow, 0);
        rst = 1'b1;
        tick(3);

        // Acks with an empty FIFO must be ignored.
        poke_ack = 1;
        tick(3);
        poke_ack = 0;
        tick(2);
        check("ack_empty_writeflag", WriteFlag, 0);
        check("ack_empty_overflow", overflow, 0);

        // One line of 1600 bytes 0x12,0x34,...
        ack_en = 1;
        new_frame();
        p0 = pops;
        line_begin();
        for (int i = 0; i < 800; i++) send_px(8'h12, 8'h34);
        line_end();
        wait_drain("t1");
        check("t1_pops", pops - p0, 800);
        check("t1_last_addr", last_addr, 24'h00031F);
        check("t1_last_pix", last_pix, T1_LAST);

        // Overlong line of 1700 bytes: columns beyond 799 are discarded silently.
        new_frame();
        p0 = pops;
        line_begin();
        for (int i = 0; i < 850; i++) send_px(8'(2 * i), 8'(2 * i + 1));
        line_end();
        wait_drain("t2");
        check("t2_pops", pops - p0, 800);
        check("t2_last_addr", last_addr, 24'h00031F);
        check("t2_last_pix", last_pix, T2_LAST);
        check("t2_overflow", overflow, 0);

        // Ack held low for 20 pixels: 16 stored, overflow on the 17th.
        ack_en = 0;
        new_frame();
        p0 = pops;
        line_begin();
        for (int i = 0; i < 16; i++) send_px(8'hA0, 8'(i));
        tick(4);
        check("t3_overflow_after_16", overflow, 0);
        check("t3_writeflag_full", WriteFlag, 1);
        send_px(8'hA0, 8'd16);
        tick(4);
        check("t3_overflow_after_17", overflow, 1);
        for (int i = 17; i < 20; i++) send_px(8'hA0, 8'(i));
        line_end();
        check("t3_model_depth", model_q.size(), 16);
        ack_en = 1;
        wait_drain("t3");
        check("t3_pops", pops - p0, 16);
        check("t3_last_addr", last_addr, 24'h00000F);
`ifndef CAM_TEST_PATTERN_EN
        check("t3_last_pix", last_pix, T3_LAST_RAW);
`endif
        check("t3_overflow_held", overflow, 1);
        new_frame();
        check("t3_overflow_cleared", overflow, 0);

        // Full frame (V lines of H pixels) with immediate acks.
        p0  = pops;
        fd0 = fd_count;
        for (int r = 0; r < V; r++) begin
            line_begin();
            for (int k = 0; k < H; k++) send_px(8'(r * 16 + k), 8'(k / 8));
            line_end();
        end
        wait_drain("t4");
        check("t4_pops", pops - p0, 3200);
        check("t4_frame_done_count", fd_count - fd0, 1);
        check("t4_last_addr", last_addr, 24'h001B1F);

        // Reset mid-line with 5 entries queued.
        ack_en = 0;
        new_frame();
        line_begin();
        for (int i = 0; i < 5; i++) send_px(8'h55, 8'(i));
        tick(4);
        check("t5_writeflag_queued", WriteFlag, 1);
        check("t5_model_depth", model_q.size(), 5);
        rst = 1'b0;
        #1;
        check("t5_rst_writeflag", WriteFlag, 0);
        check("t5_rst_data_out", DATA_out, 0);
        check("t5_rst_data_addr", DATA_addr, 0);
        model_q.delete();
        live = 0;
        tick(1);
        rst    = 1'b1;
        ack_en = 1;
        p0     = pops;
        for (int i = 5; i < 11; i++) send_px(8'h55, 8'(i));
        line_end();
        line_begin();
        for (int i = 0; i < 4; i++) send_px(8'h66, 8'(i));
        line_end();
        check("t5_no_capture_writeflag", WriteFlag, 0);
        check("t5_no_capture_pops", pops - p0, 0);

        // Next frame with V+1 short lines: the extra line is dropped.
        new_frame();
        p0 = pops;
        for (int r = 0; r < V + 1; r++) begin
            line_begin();
            for (int k = 0; k < 2; k++) send_px(8'(8'h60 + r), 8'(k));
            line_end();
        end
        wait_drain("t6");
        check("t6_pops", pops - p0, 8);
        check("t6_last_addr", last_addr, 24'h001801);
        check("t6_overflow", overflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/camera_frame_writer.md
CAMERA_FRAME_WRITER -- requirements
Module: camera_frame_writer

Interface
REQ-001 Parameter H_PIXELS, default 800, pixels stored per line.
REQ-002 Parameter V_LINES, default 600, lines stored per frame.
REQ-003 Parameter FIFO_AW, default 4, log2 of FIFO depth (16 entries).
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 cam_pclk  in  1  camera pixel clock, sampled as data in clk domain.
REQ-007 cam_href  in  1  camera line-valid, high during active bytes.
REQ-008 cam_vsync  in  1  camera frame sync, high between frames.
REQ-009 cam_data  in  8  camera byte bus.
REQ-010 DATA_out  out  16  pixel word at FIFO head.
REQ-011 DATA_addr  out  24  [10:0] column, [21:11] row, [23:22] zero.
REQ-012 WriteFlag  out  1  SDRAM write request; downstream line reader yields the bus while high.
REQ-013 DATA_out_ack  in  1  one-cycle pulse: SDRAM accepted current DATA_out/DATA_addr.
REQ-014 frame_done  out  1  one-cycle pulse when last pixel of frame is accepted.
REQ-015 overflow  out  1  sticky flag: a pixel was dropped due to full FIFO.

Function
REQ-016 cam_pclk, cam_href, cam_vsync SHALL pass 2-flop synchronizers; cam_data SHALL be registered alongside; pclk rising edge = synced pclk 1 now, 0 previous cycle.
REQ-017 clk SHALL be >= 4x cam_pclk frequency; slower clk is unsupported.
REQ-018 Capture FSM: S_WAITFRAME -> S_CAPTURE on synced vsync falling edge; S_CAPTURE -> S_WAITFRAME on vsync rising edge.
REQ-019 S_WAITFRAME: row and column capture counters = 0, byte phase = 0, no pushes.
REQ-020 S_CAPTURE, pclk edge with href=1: phase 0 stores byte as high byte; phase 1 forms {high, current} and pushes; phase toggles.
REQ-021 href falling edge SHALL reset phase to 0, column to 0, and increment row if column was nonzero.
REQ-022 Pushes with column >= H_PIXELS or row >= V_LINES SHALL be discarded without setting overflow.
REQ-023 Each FIFO entry SHALL hold 38 bits: pixel, column, row; DATA_addr is taken from the head entry.
REQ-024 Push when FIFO full SHALL drop the pixel, set overflow, and still advance column.
REQ-025 WriteFlag SHALL equal registered FIFO non-empty; first assertion one cycle after first push.
REQ-026 DATA_out_ack while FIFO non-empty SHALL pop one entry; ack while empty SHALL be ignored.
REQ-027 Simultaneous push and pop SHALL both occur, count unchanged; push into full FIFO with pop in same cycle SHALL succeed.
REQ-028 frame_done SHALL pulse the cycle after popping an entry with column H_PIXELS-1 and row V_LINES-1.
REQ-029 overflow SHALL clear on S_WAITFRAME -> S_CAPTURE transition.
REQ-030 vsync rising mid-line SHALL abort capture; FIFO contents SHALL still drain normally.

Reset
REQ-031 On rst low: FSM S_WAITFRAME, FIFO empty, counters 0, synchronizers 0, DATA_out 0, DATA_addr 0, WriteFlag 0, frame_done 0, overflow 0.
REQ-032 Reset asserted mid-frame SHALL discard FIFO contents immediately; capture resumes only after next vsync falling edge.

Configuration
REQ-033 Macro CAM_TEST_PATTERN_EN: when defined, pushed pixel SHALL be colour bars, RGB444 in [11:0] = {col[9:7] nonzero bits mapped: bit7->R=F, bit8->G=F, bit9->B=F}, [15:12]=0, camera bytes ignored; timing still from href/pclk.
REQ-034 Without CAM_TEST_PATTERN_EN, pixel = assembled camera bytes, no pattern logic synthesized.

Verification
REQ-035 Reset, vsync fall, 1 line of 1600 bytes 0x12,0x34..., ack each WriteFlag -> 800 words 0x1234 at addr row 0, col 0..799, WriteFlag low after drain.
REQ-036 Line of 1700 bytes -> exactly 800 pops, cols 0..799, overflow stays 0.
REQ-037 Hold DATA_out_ack low for 20 pixels -> 16 stored, overflow=1 at 17th push; cleared at next vsync fall.
REQ-038 Full 800x600 frame with immediate acks -> frame_done pulses once, one cycle after pop of row 599 col 799.
REQ-039 Assert rst low mid-line with 5 entries queued -> WriteFlag 0 next cycle, no further pops; 601st line ignored on later frame.
REQ-040 With CAM_TEST_PATTERN_EN, one line -> col 0..127 = 0x0000, col 128 = 0x0F00, col 896-range unreachable, col 384 = 0x0FF0.
